// File: rtl/face_color_sampler.sv
// Reads an 8x8 (2^S_WIN square) window centred on each of the 3x3 cube-face cells
// from frame RAM and emits the per-cell RGB565 average, one result per cell.
module face_color_sampler #(
  parameter int LINES  = 120,
  parameter int PIXELS = 160,
  parameter int S_ADDR = 15,
  parameter int S_WIN  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  output logic [S_ADDR-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic              res_valid,
  output logic [3:0]        res_index,
  output logic [15:0]       res_rgb,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int WIN = 1 << S_WIN;
  localparam int CH  = LINES / 3;
  localparam int CW  = PIXELS / 3;
  localparam int RW  = 5 + 2*S_WIN;
  localparam int GW  = 6 + 2*S_WIN;

  // Window origin of cell 0 and the strides between cells; all elaboration-time constants.
  localparam logic [S_ADDR-1:0] ORG0      = S_ADDR'((CH/2 - WIN/2)*PIXELS + (CW/2 - WIN/2));
  localparam logic [S_ADDR-1:0] ROW_STEP  = S_ADDR'(CH*PIXELS);
  localparam logic [S_ADDR-1:0] COL_STEP  = S_ADDR'(CW);
  localparam logic [S_ADDR-1:0] LINE_STEP = S_ADDR'(PIXELS);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SETUP  = 4'd1,
    READ   = 4'd2,
    DRAIN  = 4'd3,
    RESULT = 4'd4,
    NEXT   = 4'd5,
    DONE   = 4'd6
  } state_t;

  state_t            state, state_nxt;
  logic [S_WIN-1:0]  wcol, wrow;
  logic [1:0]        cell_c;
  logic [3:0]        cell_idx;
  logic [S_ADDR-1:0] row_org, cell_org, line_base;
  logic              smp_vld;
  logic [RW-1:0]     acc_r, acc_b;
  logic [GW-1:0]     acc_g;
  logic              win_last;

  assign win_last = &{wrow, wcol};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iniciar) state_nxt = SETUP;
      SETUP:   state_nxt = READ;
      READ:    if (win_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = RESULT;
      RESULT:  state_nxt = NEXT;
      NEXT:    state_nxt = (cell_idx < 4'd8) ? SETUP : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      res_valid <= 1'b0;
      res_index <= '0;
      res_rgb   <= '0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= '0;
      wcol      <= '0;
      wrow      <= '0;
      cell_c    <= '0;
      cell_idx  <= '0;
      row_org   <= '0;
      cell_org  <= '0;
      line_base <= '0;
      smp_vld   <= 1'b0;
      acc_r     <= '0;
      acc_g     <= '0;
      acc_b     <= '0;
    end else begin
      state     <= state_nxt;
      // Status outputs are registered from the current state (one clock behind it).
      ocupado   <= (state != IDLE);
      pronto    <= (state == DONE);
      res_valid <= (state == RESULT);
      db_estado <= state;
      // RAM data lags the address by one clock, so the sample flag is READ delayed by one.
      smp_vld   <= (state == READ);

      if (smp_vld) begin
        acc_r <= acc_r + {{(RW-5){1'b0}}, mem_data[15:11]};
        acc_g <= acc_g + {{(GW-6){1'b0}}, mem_data[10:5]};
        acc_b <= acc_b + {{(RW-5){1'b0}}, mem_data[4:0]};
      end

      case (state)
        IDLE: if (iniciar) begin
          cell_idx <= '0;
          cell_c   <= '0;
          row_org  <= ORG0;
          cell_org <= ORG0;
        end
        SETUP: begin
          mem_addr  <= cell_org;
          line_base <= cell_org;
          wcol      <= '0;
          wrow      <= '0;
          acc_r     <= '0;
          acc_g     <= '0;
          acc_b     <= '0;
        end
        READ: if (!win_last) begin
          if (&wcol) begin
            wcol      <= '0;
            wrow      <= wrow + 1'b1;
            line_base <= line_base + LINE_STEP;
            mem_addr  <= line_base + LINE_STEP;
          end else begin
            wcol     <= wcol + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        RESULT: begin
          res_index <= cell_idx;
          res_rgb   <= {acc_r[RW-1 -: 5], acc_g[GW-1 -: 6], acc_b[RW-1 -: 5]};
        end
        NEXT: if (cell_idx < 4'd8) begin
          cell_idx <= cell_idx + 4'd1;
          if (cell_c == 2'd2) begin
            cell_c   <= '0;
            row_org  <= row_org + ROW_STEP;
            cell_org <= row_org + ROW_STEP;
          end else begin
            cell_c   <= cell_c + 2'd1;
            cell_org <= cell_org + COL_STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_face_color_sampler.sv
// Scoreboard bench for face_color_sampler: directed frames, expected results queued at start.
module tb_face_color_sampler;

  localparam int LINES  = 120;
  localparam int PIXELS = 160;
  localparam int S_ADDR = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              iniciar = 1'b0;
  logic [S_ADDR-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              res_valid;
  logic [3:0]        res_index;
  logic [15:0]       res_rgb;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;

  face_color_sampler #(.LINES(LINES), .PIXELS(PIXELS), .S_ADDR(S_ADDR), .S_WIN(3)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .mem_addr(mem_addr),
    .mem_data(mem_data), .res_valid(res_valid), .res_index(res_index),
    .res_rgb(res_rgb), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [LINES*PIXELS];
  always @(posedge clock) mem_data <= mem[int'(mem_addr)];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int idx; int rgb; } res_t;
  res_t exp_q[$];
  int   addr_q[$];
  bit   cap_en = 1'b0;
  int   last_addr = 0;

  int ls[3] = '{16, 56, 96};
  int cs[3] = '{22, 75, 128};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", nm, act, act, exp, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clock) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_index", int'(res_index), -1);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("res_index", int'(res_index), e.idx);
        chk("res_rgb", int'(res_rgb), e.rgb);
      end
    end
    if (cap_en && int'(mem_addr) != last_addr) begin
      addr_q.push_back(int'(mem_addr));
      last_addr = int'(mem_addr);
    end
  end

  task automatic fill_all(input logic [15:0] v);
    for (int i = 0; i < LINES*PIXELS; i++) mem[i] = v;
  endtask

  task automatic fill_win(input int k, input logic [15:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[(ls[k/3]+r)*PIXELS + cs[k%3] + c] = v;
  endtask

  task automatic push_exp(input int k, input int rgb);
    res_t e;
    e.idx = k;
    e.rgb = rgb;
    exp_q.push_back(e);
  endtask

  task automatic start_pulse();
    @(negedge clock);
    iniciar = 1'b1;
    @(posedge clock);
    #1 iniciar = 1'b0;
  endtask

  // One full pass; x1/x2 are cycle numbers after which an extra iniciar is raised.
  task automatic run_pass(input string nm, input int x1, input int x2);
    int lat, npr, gaps;
    lat = 0; npr = 0; gaps = 0;
    start_pulse();
    for (int n = 1; n <= 700; n++) begin
      @(posedge clock);
      #1;
      iniciar = (n == x1 || n == x2);
      if (pronto) begin
        npr++;
        if (lat == 0) lat = n;
      end
      if (n <= 613 && !ocupado) gaps++;
    end
    iniciar = 1'b0;
    chk({nm, "_pronto_latency"}, lat, 613);
    chk({nm, "_pronto_count"}, npr, 1);
    chk({nm, "_ocupado_gaps"}, gaps, 0);
    chk({nm, "_idle_after"}, int'(ocupado), 0);
    chk({nm, "_results_left"}, exp_q.size(), 0);
  endtask

  task automatic per_cell_frame();
    fill_all(16'hFFFF);
    for (int k = 0; k < 9; k++) fill_win(k, 16'(16'h0841 * k));
  endtask

  initial begin
    fill_all(16'h0000);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_db_estado", int'(db_estado), 0);
    chk("rst_res_rgb", int'(res_rgb), 0);
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);

    // Uniform red frame, with address trace capture.
    fill_all(16'hF800);
    for (int k = 0; k < 9; k++) push_exp(k, 16'hF800);
    cap_en = 1'b1;
    run_pass("uniform", -1, -1);
    cap_en = 1'b0;
    chk("addr_count", addr_q.size(), 576);
    chk("addr_first", addr_q[0], 2582);
    chk("addr_8th", addr_q[7], 2589);
    chk("addr_9th", addr_q[8], 2742);
    chk("addr_cell1_first", addr_q[64], 2635);
    chk("addr_cell8_last", addr_q[575], 16615);
    begin
      int bad, i;
      bad = 0; i = 0;
      if (addr_q.size() != 576) bad = 9999;
      else
        for (int k = 0; k < 9; k++)
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
              if (addr_q[i] != (ls[k/3]+r)*PIXELS + cs[k%3] + c) bad++;
              i++;
            end
      chk("addr_trace_bad", bad, 0);
    end

    // Distinct constant per cell inside bright surroundings.
    per_cell_frame();
    for (int k = 0; k < 9; k++) push_exp(k, int'(16'(16'h0841 * k)));
    run_pass("per_cell", -1, -1);

    // Truncating average: G sum 64 -> 1, R/B sums 32 -> 0.
    fill_all(16'hFFFF);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mem[(16+r)*PIXELS + 22 + c] = ((r + c) % 2 == 0) ? 16'h0000 : 16'h0841;
    push_exp(0, 16'h0020);
    for (int k = 1; k < 9; k++) push_exp(k, 16'hFFFF);
    run_pass("trunc", -1, -1);

    // Reset during cell 4 READ, then a clean pass.
    per_cell_frame();
    for (int k = 0; k < 4; k++) push_exp(k, int'(16'(16'h0841 * k)));
    start_pulse();
    repeat (299) @(posedge clock);
    #1 chk("pre_abort_estado", int'(db_estado), 2);
    @(negedge clock) reset = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_mem_addr", int'(mem_addr), 0);
    chk("abort_res_index", int'(res_index), 0);
    chk("abort_res_rgb", int'(res_rgb), 0);
    chk("abort_ocupado", int'(ocupado), 0);
    chk("abort_db_estado", int'(db_estado), 0);
    @(negedge clock) reset = 1'b1;
    repeat (100) @(posedge clock);
    #1 chk("abort_stays_idle", int'(ocupado), 0);
    chk("abort_results_left", exp_q.size(), 0);
    for (int k = 0; k < 9; k++) push_exp(k, int'(16'(16'h0841 * k)));
    run_pass("after_abort", -1, -1);

    // iniciar while busy and on the pronto edge must both be ignored.
    for (int k = 0; k < 9; k++) push_exp(k, int'(16'(16'h0841 * k)));
    run_pass("busy_start", 100, 612);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
